div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin two-requester front end for a shared divider; define DIV_ZERO_BYPASS_EN for divide-by-zero bypass
module div_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        REQ0_VALID,
  input  logic        REQ1_VALID,
  input  logic [31:0] REQ0_OP1,
  input  logic [31:0] REQ0_OP2,
  input  logic [31:0] REQ1_OP1,
  input  logic [31:0] REQ1_OP2,
  input  logic [1:0]  REQ0_CMD,
  input  logic [1:0]  REQ1_CMD,
  output logic        REQ0_ACCEPT,
  output logic        REQ1_ACCEPT,
  output logic        RES0_VALID,
  output logic        RES1_VALID,
  output logic [31:0] RES_DATA,
  input  logic        RES0_POP,
  input  logic        RES1_POP,
  input  logic        FLUSH,
  output logic        START_DIV,
  output logic [31:0] DIV_OP1,
  output logic [31:0] DIV_OP2,
  output logic [1:0]  DIV_CMD,
  input  logic        BUSY_DIV,
  input  logic        DONE_DIV,
  input  logic [31:0] RES_DIV
);
  typedef enum logic [2:0] {IDLE, START, WAIT, HOLD, DRAIN} state_t;
  state_t state, state_nxt;
  logic ptr, owner, win, take, pop, bypass;
  assign win  = REQ1_VALID & (~REQ0_VALID | ptr);
  assign take = (state == IDLE) & ~FLUSH & (REQ0_VALID | REQ1_VALID);
  assign pop  = owner ? RES1_POP : RES0_POP;
`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = (DIV_OP2 == '0);
`else
  assign bypass = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_nxt;
  // a flush landing on the DONE cycle has nothing left to drain
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = take ? START : IDLE;
      START:   state_nxt = FLUSH ? IDLE : bypass ? HOLD : BUSY_DIV ? START : WAIT;
      WAIT:    state_nxt = FLUSH ? (DONE_DIV ? IDLE : DRAIN) : DONE_DIV ? HOLD : WAIT;
      HOLD:    state_nxt = (FLUSH | pop) ? IDLE : HOLD;
      DRAIN:   state_nxt = DONE_DIV ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    REQ0_ACCEPT = reset_n & take & ~win;
    REQ1_ACCEPT = reset_n & take & win;
    START_DIV   = reset_n & (state == START) & ~FLUSH & ~bypass & ~BUSY_DIV;
    RES0_VALID  = (state == HOLD) & ~owner;
    RES1_VALID  = (state == HOLD) & owner;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      DIV_OP1  <= '0;
      DIV_OP2  <= '0;
      DIV_CMD  <= '0;
      RES_DATA <= '0;
    end else begin
      if (take) begin
        ptr     <= ~win;
        owner   <= win;
        DIV_OP1 <= win ? REQ1_OP1 : REQ0_OP1;
        DIV_OP2 <= win ? REQ1_OP2 : REQ0_OP2;
        DIV_CMD <= win ? REQ1_CMD : REQ0_CMD;
      end
      if (state == START && bypass && !FLUSH)
        RES_DATA <= DIV_CMD[1] ? DIV_OP1 : '1;
      else if (state == WAIT && DONE_DIV && !FLUSH)
        RES_DATA <= RES_DIV;
    end
  end
endmodule
